// File: rtl/i2s_frame_feeder.sv
`default_nettype none
// ============================================================================
// Module   : i2s_frame_feeder
// Brief    : Generates I2S sck/ws from clk and holds one staged stereo sample,
//            committing it to left_chan/right_chan at mid right slot.
//            Build macro I2S_FEED_MUTE_ON_UNDERRUN_EN: mute outputs on underrun.
// Revision : 1.0 - initial release
// ============================================================================
module i2s_frame_feeder #(
    parameter int DAT_WDTH = 24,
    parameter int SYS_WDTH = 32,
    parameter int DIV      = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [DAT_WDTH-1:0] s_left,
    input  logic [DAT_WDTH-1:0] s_right,
    output logic                sck,
    output logic                ws,
    output logic [DAT_WDTH-1:0] left_chan,
    output logic [DAT_WDTH-1:0] right_chan,
    output logic                frame_start,
    output logic                underrun
);

    localparam int c_DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int c_BIT_W = $clog2(2 * SYS_WDTH);

    localparam logic [c_DIV_W-1:0] c_DIV_LAST   = c_DIV_W'(DIV - 1);
    localparam logic [c_BIT_W-1:0] c_BIT_LAST   = c_BIT_W'(2 * SYS_WDTH - 1);
    localparam logic [c_BIT_W-1:0] c_BIT_RIGHT  = c_BIT_W'(SYS_WDTH);
    localparam logic [c_BIT_W-1:0] c_BIT_COMMIT = c_BIT_W'(SYS_WDTH + SYS_WDTH / 2);

    logic [c_DIV_W-1:0]  r_div_cnt;
    logic [c_BIT_W-1:0]  r_bit_cnt;
    logic                r_sck;
    logic                r_ws;
    logic                r_frame_start;
    logic                r_underrun;
    logic                r_full;
    logic [DAT_WDTH-1:0] r_stage_left;
    logic [DAT_WDTH-1:0] r_stage_right;
    logic [DAT_WDTH-1:0] r_left_chan;
    logic [DAT_WDTH-1:0] r_right_chan;

    logic                w_div_wrap;
    logic                w_fall;
    logic [c_BIT_W-1:0]  w_bit_cnt_next;
    logic                w_commit;
    logic                w_accept;

    assign w_div_wrap = (r_div_cnt == c_DIV_LAST);
    assign w_fall     = w_div_wrap & r_sck;

    // 2*SYS_WDTH need not be a power of two, so wrap explicitly
    always_comb begin
        w_bit_cnt_next = r_bit_cnt;
        if (w_fall) begin
            w_bit_cnt_next = (r_bit_cnt == c_BIT_LAST) ? '0 : r_bit_cnt + 1'b1;
        end
    end

    assign w_commit = w_fall & (w_bit_cnt_next == c_BIT_COMMIT);
    assign w_accept = s_valid & ~r_full;

    // Clock / framing generation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div_cnt     <= '0;
            r_bit_cnt     <= c_BIT_LAST;
            r_sck         <= 1'b0;
            r_ws          <= 1'b1;
            r_frame_start <= 1'b0;
        end else begin
            r_div_cnt     <= w_div_wrap ? '0 : r_div_cnt + 1'b1;
            r_frame_start <= w_fall & (w_bit_cnt_next == '0);
            if (w_div_wrap) begin
                r_sck <= ~r_sck;
            end
            if (w_fall) begin
                r_bit_cnt <= w_bit_cnt_next;
                r_ws      <= (w_bit_cnt_next >= c_BIT_RIGHT);
            end
        end
    end

    // Staging and commit; accept is only possible while empty, so a commit in
    // the same cycle always sees an empty stage and flags underrun.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_full        <= 1'b0;
            r_stage_left  <= '0;
            r_stage_right <= '0;
            r_left_chan   <= '0;
            r_right_chan  <= '0;
            r_underrun    <= 1'b0;
        end else begin
            r_underrun <= w_commit & ~r_full;
            if (w_commit && r_full) begin
                r_left_chan  <= r_stage_left;
                r_right_chan <= r_stage_right;
            end else if (w_commit) begin
`ifdef I2S_FEED_MUTE_ON_UNDERRUN_EN
                r_left_chan  <= '0;
                r_right_chan <= '0;
`else
                // repeat last sample: outputs hold
                r_left_chan  <= r_left_chan;
                r_right_chan <= r_right_chan;
`endif
            end
            if (w_accept) begin
                r_stage_left  <= s_left;
                r_stage_right <= s_right;
                r_full        <= 1'b1;
            end else if (w_commit) begin
                r_full <= 1'b0;
            end
        end
    end

    assign s_ready     = ~r_full;
    assign sck         = r_sck;
    assign ws          = r_ws;
    assign frame_start = r_frame_start;
    assign underrun    = r_underrun;
    assign left_chan   = r_left_chan;
    assign right_chan  = r_right_chan;

endmodule
`default_nettype wire

// File: tb/tb_i2s_frame_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2s_frame_feeder
// Brief    : Self-checking bench for i2s_frame_feeder against a frame-timing
//            and one-entry-buffer model derived from edge counts.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2s_frame_feeder;

    localparam int DAT_WDTH = 24;
    localparam int SYS_WDTH = 32;
    localparam int DIV      = 4;
    localparam int c_FRAME_BITS = 2 * SYS_WDTH;

`ifdef I2S_FEED_MUTE_ON_UNDERRUN_EN
    localparam bit c_MUTE = 1'b1;
`else
    localparam bit c_MUTE = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                s_valid = 1'b0;
    logic                s_ready;
    logic [DAT_WDTH-1:0] s_left = '0;
    logic [DAT_WDTH-1:0] s_right = '0;
    logic                sck;
    logic                ws;
    logic [DAT_WDTH-1:0] left_chan;
    logic [DAT_WDTH-1:0] right_chan;
    logic                frame_start;
    logic                underrun;

    i2s_frame_feeder #(
        .DAT_WDTH (DAT_WDTH),
        .SYS_WDTH (SYS_WDTH),
        .DIV      (DIV)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_left      (s_left),
        .s_right     (s_right),
        .sck         (sck),
        .ws          (ws),
        .left_chan   (left_chan),
        .right_chan  (right_chan),
        .frame_start (frame_start),
        .underrun    (underrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: m_t is the number of clk edges since reset release
    int                  m_t = 0;
    bit                  m_full = 1'b0;
    bit                  m_ur = 1'b0;
    logic [DAT_WDTH-1:0] m_sl = '0;
    logic [DAT_WDTH-1:0] m_sr = '0;
    logic [DAT_WDTH-1:0] m_l = '0;
    logic [DAT_WDTH-1:0] m_r = '0;

    function automatic int falls(input int t);
        return t / (2 * DIV);
    endfunction

    function automatic bit fall_edge(input int t);
        return (t > 0) && (t % (2 * DIV) == 0);
    endfunction

    // Bit position reached on the n-th fall (first fall is bit 0)
    function automatic int bit_pos(input int t);
        return (falls(t) - 1) % c_FRAME_BITS;
    endfunction

    function automatic bit exp_sck(input int t);
        return ((t / DIV) % 2) == 1;
    endfunction

    function automatic bit exp_ws(input int t);
        if (falls(t) == 0) return 1'b1;
        return bit_pos(t) >= SYS_WDTH;
    endfunction

    function automatic bit exp_fs(input int t);
        return fall_edge(t) && (bit_pos(t) == 0);
    endfunction

    function automatic bit is_commit(input int t);
        return fall_edge(t) && (bit_pos(t) == SYS_WDTH + SYS_WDTH / 2);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s t=%0d: got %h expected %h", name, m_t, act, exp);
        end
    endtask

    // Model update and per-cycle compare
    always @(posedge clk) begin
        bit acc;
        bit com;
        if (rst) begin
            m_t    = 0;
            m_full = 1'b0;
            m_ur   = 1'b0;
            m_l    = '0;
            m_r    = '0;
        end else begin
            m_t  = m_t + 1;
            acc  = s_valid && !m_full;
            com  = is_commit(m_t);
            m_ur = com && !m_full;
            if (com && m_full) begin
                m_l    = m_sl;
                m_r    = m_sr;
                m_full = 1'b0;
            end else if (com && c_MUTE) begin
                m_l = '0;
                m_r = '0;
            end
            if (acc) begin
                m_sl   = s_left;
                m_sr   = s_right;
                m_full = 1'b1;
            end
        end
        #1;
        check("sck", {31'b0, sck}, {31'b0, exp_sck(m_t)});
        check("ws", {31'b0, ws}, {31'b0, exp_ws(m_t)});
        check("frame_start", {31'b0, frame_start}, {31'b0, exp_fs(m_t)});
        check("underrun", {31'b0, underrun}, {31'b0, m_ur});
        check("left_chan", {8'b0, left_chan}, {8'b0, m_l});
        check("right_chan", {8'b0, right_chan}, {8'b0, m_r});
        check("s_ready", {31'b0, s_ready}, {31'b0, !m_full});
    end

    // Advance until the model reaches edge n (sampled just after that edge)
    task automatic goto(input int n);
        int guard;
        guard = 0;
        while (m_t != n) begin
            @(posedge clk);
            #2;
            guard++;
            if (guard > 20000) begin
                n_errors++;
                $display("FAIL goto_timeout: got t=%0d expected t=%0d", m_t, n);
                $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
                $fatal(1, "timeout");
            end
        end
    endtask

    // Present one pair held until accepted
    task automatic send(input logic [DAT_WDTH-1:0] l, input logic [DAT_WDTH-1:0] r);
        int guard;
        guard = 0;
        @(negedge clk);
        s_valid = 1'b1;
        s_left  = l;
        s_right = r;
        while (!s_ready) begin
            @(negedge clk);
            guard++;
            if (guard > 2000) begin
                n_errors++;
                $display("FAIL send_timeout: got s_ready=0 expected 1 within 2000 cycles");
                break;
            end
        end
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_valid_at(input int n, input logic [DAT_WDTH-1:0] l,
                                  input logic [DAT_WDTH-1:0] r);
        goto(n - 1);
        @(negedge clk);
        s_valid = 1'b1;
        s_left  = l;
        s_right = r;
        @(posedge clk);
        #2;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Free-running timing anchors
        goto(3);
        check("sck_before_rise", {31'b0, sck}, 32'd0);
        goto(4);
        check("sck_first_rise", {31'b0, sck}, 32'd1);
        goto(8);
        check("first_frame_start", {31'b0, frame_start}, 32'd1);
        check("ws_low_at_frame", {31'b0, ws}, 32'd0);

        // Single sample accepted at edge 20
        pulse_valid_at(20, 24'hABCDEF, 24'h123456);
        check("ready_after_accept", {31'b0, s_ready}, 32'd0);
        @(negedge clk);
        s_valid = 1'b0;
        goto(263);
        check("ws_end_left", {31'b0, ws}, 32'd0);
        goto(264);
        check("ws_right_slot", {31'b0, ws}, 32'd1);
        goto(391);
        check("left_before_commit", {8'b0, left_chan}, 32'd0);
        goto(392);
        check("left_first_commit", {8'b0, left_chan}, 32'hABCDEF);
        check("right_first_commit", {8'b0, right_chan}, 32'h123456);
        check("ready_after_commit", {31'b0, s_ready}, 32'd1);
        goto(520);
        check("second_frame_start", {31'b0, frame_start}, 32'd1);

        // Backpressure: valid held, one accept per frame
        send(24'h111111, 24'hAAAAAA);
        send(24'h222222, 24'hBBBBBB);
        send(24'h000111, 24'h000222);
        @(negedge clk);
        s_valid = 1'b0;
        goto(1928);
        check("stream_last_left", {8'b0, left_chan}, 32'h000111);

        // Underrun in the following frame
        goto(2440);
        check("underrun_pulse", {31'b0, underrun}, 32'd1);
        check("underrun_left", {8'b0, left_chan}, c_MUTE ? 32'd0 : 32'h000111);

        // Accept on the commit edge with empty staging
        pulse_valid_at(2952, 24'h5A5A5A, 24'hA5A5A5);
        check("simul_underrun", {31'b0, underrun}, 32'd1);
        check("simul_ready", {31'b0, s_ready}, 32'd0);
        check("simul_right", {8'b0, right_chan}, c_MUTE ? 32'd0 : 32'h000222);
        @(negedge clk);
        s_valid = 1'b0;
        goto(3464);
        check("simul_next_commit", {8'b0, left_chan}, 32'h5A5A5A);

        // Stage a sample, then reset 300 cycles into the frame
        pulse_valid_at(3470, 24'h777777, 24'h888888);
        @(negedge clk);
        s_valid = 1'b0;
        goto(3892);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_sck", {31'b0, sck}, 32'd0);
        check("rst_ws", {31'b0, ws}, 32'd1);
        check("rst_left", {8'b0, left_chan}, 32'd0);
        check("rst_right", {8'b0, right_chan}, 32'd0);
        check("rst_ready", {31'b0, s_ready}, 32'd1);
        check("rst_frame_start", {31'b0, frame_start}, 32'd0);
        check("rst_underrun", {31'b0, underrun}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        goto(8);
        check("restart_frame_start", {31'b0, frame_start}, 32'd1);
        goto(392);
        check("restart_underrun", {31'b0, underrun}, 32'd1);
        check("restart_left", {8'b0, left_chan}, 32'd0);

        repeat (2) @(posedge clk);
        #3;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
